mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits between exec and writeback.
- Consumes the exec stage's registered result, destination register, store data and instruction type/sub-type.
- Performs loads and stores over a req/ack data-memory port. Stalls upstream while a transaction is outstanding.
- Drives the writeback register and the mem-stage bypass (`bp_mem_reg`/`bp_mem_val`) that feeds exec operand forwarding.

Parameters:
- `ADDR_W`, 32, data-memory byte address width.
- `XLEN`, 32, datapath width.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  the single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  exec output holds a real instruction this cycle.
- `ex_insn_type`  in  4  instruction type (AR/L/S/DB/IB).
- `ex_insn_sub_type`  in  4  sub-type; for L/S it encodes access width/sign.
- `ex_rd`  in  5  destination register.
- `ex_val`  in  XLEN  ALU result: effective address for L/S, result otherwise.
- `ex_store_val`  in  XLEN  store data.
- `dmem_req`  out  1  memory request, held until ack.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  ADDR_W  word-aligned address, low two bits forced to 0.
- `dmem_wdata`  out  XLEN  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ack`  in  1  memory completes the transaction this cycle; `dmem_rdata` is valid.
- `dmem_rdata`  in  XLEN  full aligned read word.
- `mem_stall`  out  1  upstream must hold its outputs.
- `wb_valid`  out  1  writeback register holds a write.
- `wb_rd`  out  5  writeback destination.
- `wb_val`  out  XLEN  writeback value.
- `bp_mem_reg`  out  5  bypass register number; 0 = none.
- `bp_mem_val`  out  XLEN  bypass value.
- `misalign_err`  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
  - Reset asserted mid-transaction drops `dmem_req` immediately (asynchronous) and discards the access.
  - The memory must tolerate an abandoned request.
- Sub-type encodings live in the shared include: BYTE=0, HALF=1, WORD=2, BYTE_U=4, HALF_U=5.
- Writing instruction: AR, L, IB, or DB with sub-type JAL, and `ex_rd` != 0. All other instructions never set `wb_valid`.
- FSM states: IDLE, BUSY.
- IDLE, posedge with `ex_valid`:
  - Non-memory instruction: `wb_valid` <= writing; `wb_rd` <= `ex_rd`; `wb_val` <= `ex_val`. Latency 1 cycle.
  - L/S, aligned: capture address, sub-type, rd and store data; `dmem_req` <= 1; `dmem_we` <= (S); next state BUSY; `wb_valid` <= 0.
  - L/S, misaligned (HALF at addr[0]=1; WORD at addr[1:0] != 0): no request; `misalign_err` pulses for 1 cycle; `wb_valid` <= 0; stay IDLE.
- BUSY:
  - `mem_stall` = 1, combinational from state; exec inputs are ignored.
  - On posedge with `dmem_ack`: `dmem_req` <= 0; next state IDLE.
  - Load completion: `wb_valid` <= (rd != 0); `wb_val` <= formatted data.
  - Store completion: `wb_valid` <= 0.
  - Minimum load/store latency: 2 cycles from capture to writeback register.
- Store formatting:
  - BYTE: `dmem_be` = 1 << addr[1:0]; wdata = byte replicated ×4.
  - HALF: `dmem_be` = 0011 or 1100 by addr[1]; wdata = half replicated ×2.
  - WORD: `dmem_be` = 1111.
- Load formatting: select byte or half by addr[1:0]; sign-extend for BYTE/HALF, zero-extend for _U; WORD passes through. `dmem_be` on loads = 1111.
- Bypass: `bp_mem_reg` = `wb_valid` ? `wb_rd` : 0; `bp_mem_val` = `wb_val`.
  - While BUSY with a load, `bp_mem_reg` = 0, so exec never forwards a not-yet-loaded value.
- `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_be` are stable for the whole of BUSY.
- A new L/S is accepted on the cycle after ack; back-to-back operation is allowed.
- `ex_valid` = 0 in IDLE clears `wb_valid`.

Decomposition:
- L/S sub-type and instruction-type codes go in the shared `exec_insn_types.v` include, next to AR/DB/IB.
- One natural sub-module: `mem_align`, combinational. It takes (addr[1:0], sub-type, store data, rdata) and returns be, replicated wdata, formatted load value and a misalign flag.
- The FSM and pipeline registers stay in `mem_stage`.

Test Plan:
- AR, rd=5, val=0x1234 → next cycle `wb_valid`=1, `wb_rd`=5, `wb_val`=0x1234, `bp_mem_reg`=5; `mem_stall` never asserted.
- LW addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF → `dmem_addr`=0x100, be=1111, `mem_stall` high 3 cycles, then `wb_val`=0xDEADBEEF, rd visible on bypass.
- LB addr 0x103, rdata 0x80000000 → `wb_val`=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 rdata 0xBEEF0000 → 0x0000BEEF.
- SB addr 0x201, store 0x000000AB → `dmem_addr`=0x200, be=0010, wdata=0xABABABAB, `dmem_we`=1, `wb_valid`=0 after ack.
- LW addr 0x102 → no `dmem_req`, `misalign_err` 1-cycle pulse, `wb_valid`=0; SH addr 0x101 same.
- `rst_n` low while BUSY → `dmem_req`, `mem_stall`, `wb_valid` drop immediately; after release, an AR instruction writes back normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared codes for the memory stage: instruction types, L/S access sub-types
// and the stage FSM encoding.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        INSN_AR = 4'd0,
        INSN_L  = 4'd1,
        INSN_S  = 4'd2,
        INSN_DB = 4'd3,
        INSN_IB = 4'd4
    } insn_type_e;

    localparam logic [3:0] SUB_BYTE   = 4'd0;
    localparam logic [3:0] SUB_HALF   = 4'd1;
    localparam logic [3:0] SUB_WORD   = 4'd2;
    localparam logic [3:0] SUB_BYTE_U = 4'd4;
    localparam logic [3:0] SUB_HALF_U = 4'd5;

    // Direct-branch sub-type that links (writes the return address).
    localparam logic [3:0] SUB_DB_JAL = 4'd1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // True for non-memory instructions that write their destination register.
    function automatic logic is_writing_alu(input logic [3:0] insn_type,
                                           input logic [3:0] sub_type,
                                           input logic [4:0] rd);
        logic writes;
        writes = (insn_type == INSN_AR) || (insn_type == INSN_IB) ||
                 ((insn_type == INSN_DB) && (sub_type == SUB_DB_JAL));
        return writes && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane steering: store byte enables and replicated data,
// load byte/half extraction with sign or zero extension, misalignment detect.
module mem_stage_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [3:0]      sub_type,
    input  logic [XLEN-1:0] store_val,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_val,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be       = 4'b1111;
        wdata    = store_val;
        load_val = rdata;
        misalign = 1'b0;
        case (sub_type)
            SUB_BYTE, SUB_BYTE_U: begin
                be       = 4'b0001 << addr_lo;
                wdata    = {(XLEN/8){store_val[7:0]}};
                load_val = (sub_type == SUB_BYTE) ? {{(XLEN-8){byte_sel[7]}}, byte_sel}
                                                  : {{(XLEN-8){1'b0}}, byte_sel};
            end
            SUB_HALF, SUB_HALF_U: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {(XLEN/16){store_val[15:0]}};
                load_val = (sub_type == SUB_HALF) ? {{(XLEN-16){half_sel[15]}}, half_sel}
                                                  : {{(XLEN-16){1'b0}}, half_sel};
                misalign = addr_lo[0];
            end
            SUB_WORD: misalign = (addr_lo != 2'b00);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack port, stalls
// exec while busy, and drives the writeback register and mem-stage bypass.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_insn_type,
    input  logic [3:0]        ex_insn_sub_type,
    input  logic [4:0]        ex_rd,
    input  logic [XLEN-1:0]   ex_val,
    input  logic [XLEN-1:0]   ex_store_val,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_val,
    output logic [4:0]        bp_mem_reg,
    output logic [XLEN-1:0]   bp_mem_val,
    output logic              misalign_err
);

    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, misalign_q, misalign_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [3:0]        sub_q, sub_d, be_q, be_d;
    logic [4:0]        rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, wb_val_q, wb_val_d;
    logic              wb_valid_q, wb_valid_d;

    logic              busy, is_mem, is_store;
    logic [1:0]        al_addr_lo;
    logic [3:0]        al_sub, al_be;
    logic [XLEN-1:0]   al_wdata, al_load_val;
    logic              al_misalign;

    assign busy     = (state_q == S_BUSY);
    assign is_store = (ex_insn_type == INSN_S);
    assign is_mem   = (ex_insn_type == INSN_L) || is_store;

    // While idle the aligner looks at the incoming op; while busy, at the captured one.
    assign al_addr_lo = busy ? off_q : ex_val[1:0];
    assign al_sub     = busy ? sub_q : ex_insn_sub_type;

    mem_stage_align #(.XLEN(XLEN)) u_align (
        .addr_lo   (al_addr_lo),
        .sub_type  (al_sub),
        .store_val (ex_store_val),
        .rdata     (dmem_rdata),
        .be        (al_be),
        .wdata     (al_wdata),
        .load_val  (al_load_val),
        .misalign  (al_misalign)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        off_d      = off_q;
        sub_d      = sub_q;
        be_d       = be_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_val_d   = wb_val_q;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                wb_valid_d = 1'b0;
                if (ex_valid && is_mem && al_misalign) begin
                    misalign_d = 1'b1;
                end else if (ex_valid && is_mem) begin
                    state_d = S_BUSY;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {ex_val[ADDR_W-1:2], 2'b00};
                    off_d   = ex_val[1:0];
                    sub_d   = ex_insn_sub_type;
                    rd_d    = ex_rd;
                    be_d    = is_store ? al_be : 4'b1111;
                    wdata_d = is_store ? al_wdata : '0;
                end else if (ex_valid) begin
                    wb_valid_d = is_writing_alu(ex_insn_type, ex_insn_sub_type, ex_rd);
                    wb_rd_d    = ex_rd;
                    wb_val_d   = ex_val;
                end
            end
            S_BUSY: begin
                if (dmem_ack) begin
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = !we_q && (rd_q != 5'd0);
                    if (!we_q) begin
                        wb_rd_d  = rd_q;
                        wb_val_d = al_load_val;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            off_q      <= '0;
            sub_q      <= '0;
            be_q       <= '0;
            rd_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            sub_q      <= sub_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_val_q   <= wb_val_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign mem_stall    = busy;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_val       = wb_val_q;
    // A busy load has wb_valid low, so the bypass never exposes a stale value.
    assign bp_mem_reg   = wb_valid_q ? wb_rd_q : 5'd0;
    assign bp_mem_val   = wb_val_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU writeback, loads, stores,
// misalignment and asynchronous reset during a transaction.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_insn_type = 4'd0;
    logic [3:0]  ex_insn_sub_type = 4'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_val = 32'd0;
    logic [31:0] ex_store_val = 32'd0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        mem_stall, wb_valid, misalign_err;
    logic [4:0]  wb_rd, bp_mem_reg;
    logic [31:0] wb_val, bp_mem_val;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_insn_type     (ex_insn_type),
        .ex_insn_sub_type (ex_insn_sub_type),
        .ex_rd            (ex_rd),
        .ex_val           (ex_val),
        .ex_store_val     (ex_store_val),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .mem_stall        (mem_stall),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_val           (wb_val),
        .bp_mem_reg       (bp_mem_reg),
        .bp_mem_val       (bp_mem_val),
        .misalign_err     (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] t, input logic [3:0] s, input logic [4:0] rd,
                           input logic [31:0] v, input logic [31:0] sv);
        ex_valid = 1'b1;
        ex_insn_type = t;
        ex_insn_sub_type = s;
        ex_rd = rd;
        ex_val = v;
        ex_store_val = sv;
    endtask

    // Issue a load, ack it on the next edge and check the formatted result.
    task automatic run_load(input string tag, input logic [3:0] s, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] expected);
        present(INSN_L, s, 5'd3, addr, 32'd0);
        step();
        ex_valid = 1'b0;
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_ack = 1'b0;
        check({tag, "_val"}, wb_val, expected);
    endtask

    initial begin
        #12;
        check("rst_req",   {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_wbv",   {31'd0, wb_valid}, 32'd0);
        check("rst_be",    {28'd0, dmem_be}, 32'd0);
        rst_n = 1'b1;
        step();

        // ALU writeback
        present(INSN_AR, 4'd0, 5'd5, 32'h1234, 32'd0);
        check("ar_stall0", {31'd0, mem_stall}, 32'd0);
        step();
        ex_valid = 1'b0;
        check("ar_wbv", {31'd0, wb_valid}, 32'd1);
        check("ar_rd",  {27'd0, wb_rd}, 32'd5);
        check("ar_val", wb_val, 32'h1234);
        check("ar_bp",  {27'd0, bp_mem_reg}, 32'd5);
        check("ar_stall1", {31'd0, mem_stall}, 32'd0);
        step();
        check("idle_clr", {31'd0, wb_valid}, 32'd0);

        // LW with 3-cycle ack
        present(INSN_L, SUB_WORD, 5'd7, 32'h100, 32'd0);
        step();
        ex_valid = 1'b0;
        check("lw_req",  {31'd0, dmem_req}, 32'd1);
        check("lw_we",   {31'd0, dmem_we}, 32'd0);
        check("lw_addr", dmem_addr, 32'h100);
        check("lw_be",   {28'd0, dmem_be}, 32'hF);
        check("lw_st1",  {31'd0, mem_stall}, 32'd1);
        check("lw_bp0",  {27'd0, bp_mem_reg}, 32'd0);
        step();
        check("lw_st2",  {31'd0, mem_stall}, 32'd1);
        step();
        check("lw_st3",  {31'd0, mem_stall}, 32'd1);
        check("lw_addr_hold", dmem_addr, 32'h100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        step();
        dmem_ack = 1'b0;
        check("lw_st_done", {31'd0, mem_stall}, 32'd0);
        check("lw_req_done", {31'd0, dmem_req}, 32'd0);
        check("lw_wbv", {31'd0, wb_valid}, 32'd1);
        check("lw_val", wb_val, 32'hDEADBEEF);
        check("lw_bp",  {27'd0, bp_mem_reg}, 32'd7);
        check("lw_bpv", bp_mem_val, 32'hDEADBEEF);

        // Sub-word loads, issued back-to-back after each ack
        run_load("lb",  SUB_BYTE,   32'h103, 32'h80000000, 32'hFFFFFF80);
        run_load("lbu", SUB_BYTE_U, 32'h103, 32'h80000000, 32'h00000080);
        run_load("lhu", SUB_HALF_U, 32'h102, 32'hBEEF0000, 32'h0000BEEF);
        run_load("lh",  SUB_HALF,   32'h100, 32'h1234F00D, 32'hFFFFF00D);

        // SB
        present(INSN_S, SUB_BYTE, 5'd9, 32'h201, 32'h000000AB);
        step();
        ex_valid = 1'b0;
        check("sb_addr",  dmem_addr, 32'h200);
        check("sb_be",    {28'd0, dmem_be}, 32'b0010);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);
        check("sb_we",    {31'd0, dmem_we}, 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("sb_wbv", {31'd0, wb_valid}, 32'd0);
        check("sb_req", {31'd0, dmem_req}, 32'd0);

        // SH upper half
        present(INSN_S, SUB_HALF, 5'd9, 32'h302, 32'h0000C0DE);
        step();
        ex_valid = 1'b0;
        check("sh_be",    {28'd0, dmem_be}, 32'b1100);
        check("sh_wdata", dmem_wdata, 32'hC0DEC0DE);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;

        // Misaligned LW and SH
        present(INSN_L, SUB_WORD, 5'd4, 32'h102, 32'd0);
        step();
        ex_valid = 1'b0;
        check("mlw_req", {31'd0, dmem_req}, 32'd0);
        check("mlw_err", {31'd0, misalign_err}, 32'd1);
        check("mlw_wbv", {31'd0, wb_valid}, 32'd0);
        step();
        check("mlw_pulse", {31'd0, misalign_err}, 32'd0);
        present(INSN_S, SUB_HALF, 5'd4, 32'h101, 32'h5555);
        step();
        ex_valid = 1'b0;
        check("msh_req", {31'd0, dmem_req}, 32'd0);
        check("msh_err", {31'd0, misalign_err}, 32'd1);
        step();
        check("msh_pulse", {31'd0, misalign_err}, 32'd0);

        // Reset while busy
        present(INSN_L, SUB_WORD, 5'd6, 32'h400, 32'd0);
        step();
        ex_valid = 1'b0;
        check("rb_req", {31'd0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_req0",   {31'd0, dmem_req}, 32'd0);
        check("rb_stall0", {31'd0, mem_stall}, 32'd0);
        check("rb_wbv0",   {31'd0, wb_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        present(INSN_AR, 4'd0, 5'd9, 32'h55, 32'd0);
        step();
        ex_valid = 1'b0;
        check("rb_ar_wbv", {31'd0, wb_valid}, 32'd1);
        check("rb_ar_val", wb_val, 32'h55);
        check("rb_ar_rd",  {27'd0, wb_rd}, 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
